// File: rtl/pulse_width_meter.sv
// Measures high width, low width and period (in clk cycles) of a slow, clk-synchronous
// square wave; publishes one registered result per complete period with a valid strobe.
module pulse_width_meter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             meas_en,
   output logic [CNT_W-1:0] hi_width,
   output logic [CNT_W-1:0] lo_width,
   output logic [CNT_W:0]   period,
   output logic             ovf,
   output logic             meas_valid
);

   localparam int unsigned PER_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             sig_d;
   logic [CNT_W-1:0] hi_acc, hi_acc_nxt;
   logic [CNT_W-1:0] lo_acc, lo_acc_nxt;
   logic [CNT_W-1:0] hi_hold, hi_hold_nxt;
   logic             ovf_acc, ovf_acc_nxt;
   logic [CNT_W-1:0] hi_width_nxt, lo_width_nxt;
   logic [PER_W-1:0] period_nxt;
   logic             ovf_nxt, meas_valid_nxt;
   logic             rise_c, fall_c;

   // Edge detect; sig_d resets high so a level already high out of reset is not a rise.
   assign rise_c = sig_in & ~sig_d;
   assign fall_c = ~sig_in & sig_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath next values
   always_comb begin
      state_nxt      = state;
      hi_acc_nxt     = hi_acc;
      lo_acc_nxt     = lo_acc;
      hi_hold_nxt    = hi_hold;
      ovf_acc_nxt    = ovf_acc;
      hi_width_nxt   = hi_width;
      lo_width_nxt   = lo_width;
      period_nxt     = period;
      ovf_nxt        = ovf;
      meas_valid_nxt = 1'b0;

      if (!meas_en) begin
         // Disable wins over any edge and discards the partial period.
         state_nxt   = IDLE;
         hi_acc_nxt  = '0;
         lo_acc_nxt  = '0;
         hi_hold_nxt = '0;
         ovf_acc_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rise_c) begin
                  hi_acc_nxt  = CNT_ONE;
                  ovf_acc_nxt = 1'b0;
                  state_nxt   = HIGH;
               end
            end
            HIGH: begin
               if (fall_c) begin
                  hi_hold_nxt = hi_acc;
                  lo_acc_nxt  = CNT_ONE;
                  state_nxt   = LOW;
               end else if (sig_in) begin
                  if (hi_acc == CNT_MAX) begin
                     ovf_acc_nxt = 1'b1;
                  end else begin
                     hi_acc_nxt = hi_acc + CNT_ONE;
                  end
               end
            end
            LOW: begin
               if (rise_c) begin
                  // Closing rise publishes and immediately opens the next period.
                  hi_width_nxt   = hi_hold;
                  lo_width_nxt   = lo_acc;
                  period_nxt     = PER_W'(hi_hold) + PER_W'(lo_acc);
                  ovf_nxt        = ovf_acc;
                  meas_valid_nxt = 1'b1;
                  hi_acc_nxt     = CNT_ONE;
                  ovf_acc_nxt    = 1'b0;
                  state_nxt      = HIGH;
               end else if (!sig_in) begin
                  if (lo_acc == CNT_MAX) begin
                     ovf_acc_nxt = 1'b1;
                  end else begin
                     lo_acc_nxt = lo_acc + CNT_ONE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_d      <= 1'b1;
         hi_acc     <= '0;
         lo_acc     <= '0;
         hi_hold    <= '0;
         ovf_acc    <= 1'b0;
         hi_width   <= '0;
         lo_width   <= '0;
         period     <= '0;
         ovf        <= 1'b0;
         meas_valid <= 1'b0;
      end else begin
         sig_d      <= sig_in;
         hi_acc     <= hi_acc_nxt;
         lo_acc     <= lo_acc_nxt;
         hi_hold    <= hi_hold_nxt;
         ovf_acc    <= ovf_acc_nxt;
         hi_width   <= hi_width_nxt;
         lo_width   <= lo_width_nxt;
         period     <= period_nxt;
         ovf        <= ovf_nxt;
         meas_valid <= meas_valid_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: table vectors, hand-written corner sequences and
// randomized waveforms checked against a run-length reference model.
module tb_pulse_width_meter;

   localparam int unsigned CNT_W = 4;
   localparam int MAXV = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             sig_in;
   logic             meas_en;
   logic [CNT_W-1:0] hi_width;
   logic [CNT_W-1:0] lo_width;
   logic [CNT_W:0]   period;
   logic             ovf;
   logic             meas_valid;

   int checks = 0;
   int failures = 0;

   // Reference model: whole run lengths as plain integers, clipped only when published.
   int m_prev, m_active, m_phase_hi, m_hi_run, m_lo_run;
   int e_hi, e_lo, e_per, e_ovf, e_valid;

   // Per-scenario strobe bookkeeping
   int strobes, first_hi, first_lo, first_per, first_ovf;

   pulse_width_meter #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .meas_en   (meas_en),
      .hi_width  (hi_width),
      .lo_width  (lo_width),
      .period    (period),
      .ovf       (ovf),
      .meas_valid(meas_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hi_len;
      int lo_len;
      int exp_hi;
      int exp_lo;
      int exp_per;
      int exp_ovf;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int clip(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic model_step(input bit s, input bit en, input bit r);
      if (r) begin
         m_prev = 1; m_active = 0;
         e_hi = 0; e_lo = 0; e_per = 0; e_ovf = 0; e_valid = 0;
      end else begin
         e_valid = 0;
         if (!en) begin
            m_active = 0;
         end else if (!m_active) begin
            if (s && !m_prev) begin
               m_active = 1; m_phase_hi = 1; m_hi_run = 1;
            end
         end else if (m_phase_hi) begin
            if (s) m_hi_run++;
            else begin
               m_phase_hi = 0; m_lo_run = 1;
            end
         end else begin
            if (!s) m_lo_run++;
            else begin
               e_hi    = clip(m_hi_run);
               e_lo    = clip(m_lo_run);
               e_per   = e_hi + e_lo;
               e_ovf   = (m_hi_run > MAXV || m_lo_run > MAXV) ? 1 : 0;
               e_valid = 1;
               m_phase_hi = 1; m_hi_run = 1;
            end
         end
         m_prev = s;
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare all outputs after the edge.
   task automatic step(input bit s, input bit en, input bit r);
      sig_in  = s;
      meas_en = en;
      rst     = r;
      model_step(s, en, r);
      @(posedge clk);
      #1;
      chk("meas_valid", int'(meas_valid), e_valid);
      chk("hi_width",   int'(hi_width),   e_hi);
      chk("lo_width",   int'(lo_width),   e_lo);
      chk("period",     int'(period),     e_per);
      chk("ovf",        int'(ovf),        e_ovf);
      if (meas_valid) begin
         if (strobes == 0) begin
            first_hi  = int'(hi_width);
            first_lo  = int'(lo_width);
            first_per = int'(period);
            first_ovf = int'(ovf);
         end
         strobes++;
      end
   endtask

   task automatic drive(input int n, input bit s, input bit en);
      for (int i = 0; i < n; i++) step(s, en, 1'b0);
   endtask

   task automatic do_reset(input bit s);
      step(s, 1'b0, 1'b1);
      step(s, 1'b0, 1'b1);
      strobes = 0;
      first_hi = -1; first_lo = -1; first_per = -1; first_ovf = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      int   pre;
      vecs[0] = '{3, 2, 3, 2, 5, 0};
      vecs[1] = '{1, 1, 1, 1, 2, 0};
      vecs[2] = '{20, 3, 15, 3, 18, 1};
      vecs[3] = '{15, 15, 15, 15, 30, 0};
      vecs[4] = '{16, 1, 15, 1, 16, 1};
      vecs[5] = '{7, 19, 7, 15, 22, 1};

      m_prev = 1; m_active = 0; m_phase_hi = 0; m_hi_run = 0; m_lo_run = 0;
      e_hi = 0; e_lo = 0; e_per = 0; e_ovf = 0; e_valid = 0;
      strobes = 0;
      rst = 1'b1; sig_in = 1'b0; meas_en = 1'b0;

      // Reset state
      do_reset(1'b0);
      chk("reset_period", int'(period), 0);
      chk("reset_valid", int'(meas_valid), 0);

      // Table: one full period then the closing rise
      foreach (vecs[k]) begin
         do_reset(1'b0);
         drive(3, 1'b0, 1'b1);
         drive(vecs[k].hi_len, 1'b1, 1'b1);
         drive(vecs[k].lo_len, 1'b0, 1'b1);
         chk("vec_no_early_strobe", strobes, 0);
         step(1'b1, 1'b1, 1'b0);
         chk("vec_valid",  int'(meas_valid), 1);
         chk("vec_hi",     int'(hi_width),   vecs[k].exp_hi);
         chk("vec_lo",     int'(lo_width),   vecs[k].exp_lo);
         chk("vec_period", int'(period),     vecs[k].exp_per);
         chk("vec_ovf",    int'(ovf),        vecs[k].exp_ovf);
         // Following normal period must clear ovf
         drive(1, 1'b1, 1'b1);
         drive(2, 1'b0, 1'b1);
         step(1'b1, 1'b1, 1'b0);
         chk("vec_next_ovf", int'(ovf), 0);
         chk("vec_next_period", int'(period), 4);
      end

      // Basic: low 3 then high 3 / low 2 repeated five times -> 4 strobes, hold between
      do_reset(1'b0);
      drive(3, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(3, 1'b1, 1'b1);
         drive(2, 1'b0, 1'b1);
      end
      chk("basic_strobes", strobes, 4);
      chk("basic_first_per", first_per, 5);
      chk("basic_hold_hi", int'(hi_width), 3);

      // Toggle every cycle: 5 rises -> 4 strobes of 1/1/2
      do_reset(1'b0);
      drive(1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b0);
      end
      chk("toggle_strobes", strobes, 4);
      chk("toggle_first_per", first_per, 2);

      // High out of reset is ignored
      do_reset(1'b1);
      drive(4, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(2, 1'b1, 1'b1);
         drive(2, 1'b0, 1'b1);
      end
      step(1'b1, 1'b1, 1'b0);
      chk("hor_strobes", strobes, 3);
      chk("hor_first_hi", first_hi, 2);
      chk("hor_first_lo", first_lo, 2);
      chk("hor_first_per", first_per, 4);

      // Enable drop mid-LOW
      do_reset(1'b0);
      drive(3, 1'b0, 1'b1);
      drive(3, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      drive(3, 1'b1, 1'b1);
      drive(1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b1);
      pre = strobes;
      drive(3, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      chk("endrop_no_strobe", strobes - pre, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("endrop_restart_strobe", strobes - pre, 1);
      chk("endrop_restart_per", int'(period), 5);

      // Enable drop exactly on the closing rise
      drive(2, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      pre = strobes;
      step(1'b1, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b1);
      drive(4, 1'b0, 1'b1);
      drive(3, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      chk("enrise_no_strobe", strobes - pre, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("enrise_strobe", strobes - pre, 1);
      chk("enrise_lo", int'(lo_width), 2);

      // Reset mid-HIGH
      do_reset(1'b0);
      drive(3, 1'b0, 1'b1);
      drive(3, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      drive(2, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("rst_mid_hi", int'(hi_width), 0);
      chk("rst_mid_per", int'(period), 0);
      chk("rst_mid_valid", int'(meas_valid), 0);
      strobes = 0;
      drive(2, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      drive(3, 1'b1, 1'b1);
      drive(2, 1'b0, 1'b1);
      chk("rst_mid_no_strobe", strobes, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("rst_mid_strobe", strobes, 1);
      chk("rst_mid_hi_after", int'(hi_width), 3);

      // Randomized waveforms with occasional enable drops and resets
      do_reset(1'b0);
      for (int p = 0; p < 300; p++) begin
         int hl, ll;
         hl = int'($urandom_range(1, 20));
         ll = int'($urandom_range(1, 20));
         for (int c = 0; c < hl + ll; c++) begin
            bit s, en, r;
            s  = (c < hl);
            en = ($urandom_range(0, 59) != 0);
            r  = ($urandom_range(0, 299) == 0);
            step(s, en, r);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
